// File: rtl/snake_pkg.sv
//------------------------------------------------------------------------------
// Module  : snake_pkg
// Purpose : Shared direction type, reset heading and reversal helper for the
//           snake direction controller and the snake mover.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Opposite headings differ only in bit 1 (UP<->DOWN, RIGHT<->LEFT).
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// Module  : key_debounce
// Purpose : One active-low push button: 2-FF synchroniser, stability counter,
//           debounced level and a one-cycle press pulse on release->press.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count while the synchronised level disagrees with the stable level; any agreement restarts
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce state and registered press edge (levels reset to released = 1)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= key_n_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
//------------------------------------------------------------------------------
// Module  : snake_dir_ctrl
// Purpose : Turns four raw active-low buttons into the committed snake heading.
//           Debounces each key, picks one press per cycle, rejects reversals and
//           duplicates, buffers accepted turns and commits one per move_tick.
// Config  : SNAKE_DIR_QUEUE_EN defined   -> QUEUE_DEPTH-entry pending FIFO
//           SNAKE_DIR_QUEUE_EN undefined -> single overwriteable pending turn
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned QUEUE_DEPTH     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       move_tick,
  output logic [1:0] direction,
  output logic       turn_accepted,
  output logic       turn_dropped
);

  logic [3:0] press;
  logic       pick_valid;
  dir_t       pick;
  dir_t       ref_dir;
  dir_t       dir_d;
  dir_t       direction_q;
  logic       pop;
  logic       accept;
  logic       accepted_q;
  logic       dropped_q;

  if (QUEUE_DEPTH < 1) begin : g_bad_depth
    $error("snake_dir_ctrl: QUEUE_DEPTH must be at least 1");
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key_n_i(key_n[gi]),
      .press_o(press[gi])
    );
  end

  // Lowest key index wins when several presses land in the same cycle
  always_comb begin
    pick_valid = |press;
    pick       = DIR_UP;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) pick = dir_t'(2'(i));
    end
  end

`ifdef SNAKE_DIR_QUEUE_EN
  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

  dir_t             fifo_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q, count_d, post_count;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Pop first, then judge the press against the post-pop tail and occupancy
  always_comb begin
    pop        = move_tick && (count_q != '0);
    dir_d      = pop ? fifo_q[rd_ptr_q] : direction_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    post_count = pop ? count_q - 1'b1 : count_q;
    tail_ptr   = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
    ref_dir    = (post_count != '0) ? fifo_q[tail_ptr] : dir_d;
    full       = (post_count == CNT_W'(QUEUE_DEPTH));
    accept     = pick_valid && !is_reverse(pick, ref_dir) && (pick != ref_dir) && !full;
    wr_ptr_d   = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d    = accept ? post_count + 1'b1 : post_count;
  end

  // Pending-turn FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) fifo_q[i] <= DIR_RESET;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (accept) fifo_q[wr_ptr_q] <= pick;
    end
  end
`else
  dir_t pend_q, pend_d;
  logic pend_valid_q, pend_valid_d;

  // Commit the pending turn on a tick; a valid press overwrites whatever is pending
  always_comb begin
    pop          = move_tick && pend_valid_q;
    dir_d        = pop ? pend_q : direction_q;
    ref_dir      = dir_d;
    accept       = pick_valid && !is_reverse(pick, ref_dir) && (pick != ref_dir);
    pend_d       = accept ? pick : pend_q;
    pend_valid_d = accept | (pend_valid_q & ~pop);
  end

  // Single pending-turn register with its valid bit
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= DIR_RESET;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end
`endif

  // Committed heading and the one-cycle accept/drop pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      direction_q <= DIR_RESET;
      accepted_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      direction_q <= dir_d;
      accepted_q  <= accept;
      dropped_q   <= pick_valid & ~accept;
    end
  end

  assign direction     = direction_q;
  assign turn_accepted = accepted_q;
  assign turn_dropped  = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_snake_dir_ctrl
// Purpose : Self-checking bench for snake_dir_ctrl: directed scenarios plus
//           randomised presses/ticks, a queue-based reference model and a
//           scoreboard monitor for the accept/drop pulses.
// Config  : follows SNAKE_DIR_QUEUE_EN like the design
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_snake_dir_ctrl;

  localparam int D     = 4;
  localparam int DEPTH = 2;
  localparam int HOLD  = D + 8;
`ifdef SNAKE_DIR_QUEUE_EN
  localparam bit QMODE = 1'b1;
`else
  localparam bit QMODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       move_tick;
  logic [1:0] direction;
  logic       turn_accepted;
  logic       turn_dropped;

  int tests   = 0;
  int fails   = 0;
  int n_pulse = 0;

  int exp_q[$];   // 1 = accepted, 2 = dropped
  int mdir;       // model committed heading
  int mpend[$];   // model pending turns, head first

  always #5 clk = ~clk;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .QUEUE_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .move_tick    (move_tick),
    .direction    (direction),
    .turn_accepted(turn_accepted),
    .turn_dropped (turn_dropped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && (turn_accepted || turn_dropped)) begin
      n_pulse++;
      tests++;
      if (turn_accepted && turn_dropped) begin
        fails++;
        $display("FAIL pulse_both: accepted and dropped together at %0t", $time);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got %0d expected none at %0t", turn_accepted ? 1 : 2, $time);
      end else begin
        int e;
        int got;
        e   = exp_q.pop_front();
        got = turn_accepted ? 1 : 2;
        if (got != e) begin
          fails++;
          $display("FAIL pulse_kind: got %0d expected %0d at %0t", got, e, $time);
        end
      end
    end
  end

  // Reference model: a press is judged against the newest pending turn, else the heading
  function automatic void model_press(input int mask);
    int p;
    int r;
    p = 0;
    for (int i = 3; i >= 0; i--) if (mask[i]) p = i;
    r = (QMODE && mpend.size() != 0) ? mpend[$] : mdir;
    if (p == (r ^ 2) || p == r || (QMODE && mpend.size() == DEPTH)) begin
      exp_q.push_back(2);
    end else begin
      exp_q.push_back(1);
      if (!QMODE) mpend.delete();
      mpend.push_back(p);
    end
  endfunction

  function automatic void model_tick();
    if (mpend.size() != 0) mdir = mpend.pop_front();
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    mpend.delete();
    mdir = 1;
  endfunction

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  task automatic press_keys(input int mask);
    model_press(mask);
    @(negedge clk) key_n = ~4'(mask);
    repeat (HOLD) @(negedge clk);
    key_n = 4'hF;
    repeat (HOLD) @(negedge clk);
    check("press_drained", exp_q.size(), 0);
  endtask

  task automatic tick();
    model_tick();
    @(negedge clk) move_tick = 1'b1;
    @(negedge clk) move_tick = 1'b0;
    @(negedge clk);
    check("dir_after_tick", direction, mdir);
  endtask

  // Press whose debounced pulse lands in the same cycle as move_tick
  task automatic press_with_tick(input int mask);
    model_tick();
    model_press(mask);
    @(negedge clk) key_n = ~4'(mask);
    repeat (D + 3) @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk) move_tick = 1'b0;
    repeat (HOLD) @(negedge clk);
    key_n = 4'hF;
    repeat (HOLD) @(negedge clk);
    check("coinc_drained", exp_q.size(), 0);
    check("coinc_dir", direction, mdir);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset     = 1'b1;
    key_n     = 4'hF;
    move_tick = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_dir", direction, 1);
    check("reset_acc", turn_accepted, 0);
    check("reset_drop", turn_dropped, 0);
    @(negedge clk) reset = 1'b0;

    // Idle keys produce nothing
    repeat (100) @(negedge clk);
    check("idle_pulses", n_pulse, 0);

    // Bouncing UP, then stable low: exactly one acceptance
    model_press(1);
    for (int i = 0; i < 5; i++) begin
      key_n = (i % 2 == 0) ? 4'hE : 4'hF;
      repeat (2) @(negedge clk);
    end
    key_n = 4'hE;
    repeat (HOLD) @(negedge clk);
    key_n = 4'hF;
    repeat (HOLD) @(negedge clk);
    check("bounce_pulses", n_pulse, 1);
    check("bounce_drained", exp_q.size(), 0);
    tick();
    check("bounce_dir_up", direction, 0);

    // Reversal from RIGHT is dropped
    do_reset();
    press_keys(8);
    tick();
    check("reversal_dir", direction, 1);

    // Two quick turns before any tick
    do_reset();
    press_keys(1);
    press_keys(8);
    tick();
    tick();

    // Full queue accepts a press coincident with a tick
    do_reset();
    press_keys(1);
    press_keys(8);
    press_with_tick(4);
    tick();
    tick();

    // Reset discards a pending turn
    do_reset();
    press_keys(1);
    do_reset();
    check("rst_pend_dir", direction, 1);
    tick();
    check("rst_pend_tick", direction, 1);

    // Randomised mix, including simultaneous keys
    for (int n = 0; n < 40; n++) begin
      p0 = $urandom_range(0, 5);
      if (p0 == 0) tick();
      else if (p0 == 1) press_with_tick($urandom_range(1, 15));
      else press_keys($urandom_range(1, 15));
    end

    repeat (5) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
